// File: rtl/serial_addsub_unit_if.sv
// serial_addsub_unit_if: operand/op input handshake and result/flag output handshake for serial_addsub_unit
interface serial_addsub_unit_if #(parameter int WIDTH = 4);
  logic in_valid;
  logic in_ready;
  logic [1:0] op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] result;
  logic carry_out;
  logic overflow;
  logic zero;
  logic busy;
  modport master(
    output in_valid, op, a, b, out_ready,
    input in_ready, out_valid, result, carry_out, overflow, zero, busy
  );
  modport slave(
    input in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero, busy
  );
endinterface

// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit: bit-serial LSB-first ADD/SUB/INC/NEG with valid/ready handshakes; ports clk, reset, bus (slave side of serial_addsub_unit_if)
module serial_addsub_unit #(parameter int WIDTH = 4) (
  input logic clk,
  input logic reset,
  serial_addsub_unit_if.slave bus
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [WIDTH-1:0] x_q, y_q, res_q, res_d, x_d, y_d;
  logic carry_q, cout_q, ovf_q, zero_q, accept, last, s, c, cin;
  assign bus.in_ready = state_q == IDLE || (state_q == DONE && bus.out_ready);
  assign bus.out_valid = state_q == DONE;
  assign bus.busy = state_q != IDLE;
  assign bus.result = res_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero = zero_q;
  always_comb begin
    accept = bus.in_valid & bus.in_ready;
    last = idx_q == IW'(WIDTH - 1);
    s = x_q[idx_q] ^ y_q[idx_q] ^ carry_q;
    c = (x_q[idx_q] & y_q[idx_q]) | (carry_q & (x_q[idx_q] ^ y_q[idx_q]));
    res_d = res_q | (WIDTH'(s) << idx_q);
    x_d = bus.op == 2'd3 ? '0 : bus.a;
    y_d = bus.op == 2'd0 ? bus.b : bus.op == 2'd1 ? ~bus.b : bus.op == 2'd2 ? '0 : ~bus.a;
    cin = bus.op != 2'd0;
    state_d = accept ? CALC
            : (state_q == CALC && last) ? DONE
            : (state_q == DONE && bus.out_ready) ? IDLE
            : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      carry_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      res_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x_q <= x_d;
        y_q <= y_d;
        carry_q <= cin;
        idx_q <= '0;
        res_q <= '0;
        cout_q <= 1'b0;
        ovf_q <= 1'b0;
        zero_q <= 1'b0;
      end else if (state_q == CALC) begin
        res_q <= res_d;
        carry_q <= c;
        idx_q <= last ? '0 : idx_q + IW'(1);
        if (last) begin
          cout_q <= c;
          ovf_q <= carry_q ^ c;
          zero_q <= res_d == '0;
        end
      end
    end
  end
endmodule
